code_lock: RTL and testbench
============================

# code_lock

Upstream input stage for the `pass` LED stage. Takes four raw push-buttons, synchronises and debounces them, and collects a 4-digit entry. It compares the entry against a fixed code and emits a one-cycle `pass` or `fail` pulse. `pass` drives the downstream stage's pass-reset input. After `MAX_TRIES` consecutive failures the block locks out all input for `LOCK_CYCLES`.

## Interface
- `DEB_CYCLES`, 1000000: consecutive stable cycles required before a button level change is accepted (10 ms at 100 MHz).
- `CODE`, 8'h1B: four 2-bit digits; first digit in [7:6], last in [1:0].
- `MAX_TRIES`, 3: consecutive failures that trigger lockout; legal range 1–3.
- `LOCK_CYCLES`, 500000000: lockout duration in clk cycles (5 s).
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  reset, synchronous, active-high.
- `btn`  in  4  raw asynchronous buttons, active-high; a press of `btn[i]` enters digit value i.
- `pass`  out  1  one-cycle pulse on correct entry.
- `fail`  out  1  one-cycle pulse on wrong entry.
- `locked`  out  1  high during lockout.
- `digits`  out  3  count of digits entered in the current attempt, 0–4.
- `tries`  out  2  consecutive failed attempts.

## Operation
- Reset values:
  - outputs `pass`, `fail`, `locked`, `digits`, `tries` all 0;
  - FSM in IDLE;
  - debounced levels, edge history and all counters 0.
- Synchroniser: each `btn` bit passes through a 2-flop synchroniser.
- Debounce, per button:
  - a counter increments while the synchronised level differs from the accepted level;
  - the counter clears whenever the two levels match;
  - when the counter reaches DEB_CYCLES-1, the accepted level takes the synchronised value and the counter clears.
- Press event: a registered 0→1 edge of an accepted level.
  - If more than one button produces an edge in the same cycle, all of that cycle's edges are discarded.
  - Release edges are ignored.
- FSM states: IDLE, CHECK, LOCK.
  - IDLE, on a press event:
    - shift the 2-bit digit into the entry register, MSB-first;
    - increment `digits`;
    - on the 4th digit (`digits` 3→4), go to CHECK.
  - CHECK lasts one cycle and compares the entry against `CODE`.
    - Match: `pass`=1 for that one cycle; `tries`←0; `digits`←0; go to IDLE.
    - Mismatch: `fail`=1 for that one cycle; `tries`←`tries`+1; `digits`←0. If the new `tries` value equals `MAX_TRIES`, go to LOCK, otherwise go to IDLE.
  - LOCK:
    - `locked`=1;
    - the lock counter counts from 0 to LOCK_CYCLES-1;
    - at terminal count: `locked`←0, `tries`←0, lock counter←0, go to IDLE.
- Events ignored: press events arriving in CHECK or LOCK are dropped (not queued).
- Debouncing continues in all states, so a button held through lockout does not generate a press when lockout ends.
- `reset` mid-operation returns everything to reset values on the next edge, including a partial entry, `tries`, and the lock counter. An in-flight debounce is lost.

## Timing
- Latency from a clean raw press to its press event: 2 sync cycles + DEB_CYCLES + 1 edge-register cycle.
- Let edge N be the edge that samples the 4th press event:
  - at edge N: `digits`=4, state=CHECK;
  - at edge N+1: `pass` or `fail` registered high, `digits`=0, and `tries` updated;
  - `pass`/`fail` are high for exactly cycle N+1 to N+2;
  - if lockout is entered, `locked` rises at edge N+2 and stays high for exactly LOCK_CYCLES cycles.
- `pass` and `fail` are never high in the same cycle and never high in consecutive cycles.
- All outputs are registered.

## Test plan
Run the bench with DEB_CYCLES=4 and LOCK_CYCLES=20.
- Correct entry: after reset, press btn 0,1,2,3 (CODE 8'h1B) → single `pass` pulse two cycles after the 4th press event; `digits` sequence 1,2,3,4,0; `tries`=0.
- Bounce: toggle `btn[2]` every 2 cycles for 20 cycles, then hold → exactly one press event and `digits`=1. A 3-cycle glitch → no event.
- Lockout: three wrong entries (3,3,3,3) → three `fail` pulses and `tries` 1,2,3. `locked` is high for exactly 20 cycles; presses during it leave `digits` at 0; afterwards `tries`=0.
- Recovery: fail once, then enter the correct code → `pass` asserted and `tries` returns 1→0.
- Simultaneous press: `btn[0]` and `btn[1]` rise together → no event and `digits` unchanged. A single press afterwards counts normally.
- Mid-operation reset: after 2 digits, or mid-lockout at cycle 10, assert `reset` for 1 cycle → all outputs 0 on the next edge. A full correct entry then passes.

Source files
------------

// File: rtl/code_lock.sv
// code_lock: four-button combination lock front end.
// Synchronises and debounces raw buttons, collects a 4-digit entry,
// checks it against CODE and pulses pass/fail. Too many consecutive
// failures lock out all input for LOCK_CYCLES.
module code_lock #(
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter logic [7:0]  CODE        = 8'h1B,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic       pass,
  output logic       fail,
  output logic       locked,
  output logic [2:0] digits,
  output logic [1:0] tries
);

  localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [1:0]     TRY_LIM   = 2'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, CHECK, LOCK} state_t;

  // two-flop synchroniser, then accepted (debounced) level and its history
  logic [3:0]     sync_p0;
  logic [3:0]     sync_p1;
  logic [3:0]     level;
  logic [3:0]     level_prev;
  logic [DCW-1:0] deb_cnt [4];

  // press detection
  logic [3:0] rise;
  logic       press;
  logic [1:0] press_digit;

  // FSM state and next-state values
  state_t         state, state_d;
  logic [7:0]     entry, entry_d;
  logic [2:0]     digits_d;
  logic [1:0]     tries_d;
  logic [1:0]     tries_inc;
  logic           pass_d, fail_d, locked_d;
  logic [LCW-1:0] lock_cnt, lock_cnt_d;

  // Bring the asynchronous buttons into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      level      <= '0;
      level_prev <= '0;
    end else begin
      level_prev <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
      end
    end
  end

  // A press is a single rising accepted level; simultaneous rises cancel out.
  always_comb begin
    rise        = level & ~level_prev;
    press       = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
    press_digit = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) press_digit = 2'(i);
    end
  end

  // Next-state and registered-output values for entry, check and lockout.
  always_comb begin
    state_d    = state;
    entry_d    = entry;
    digits_d   = digits;
    tries_d    = tries;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    locked_d   = locked;
    lock_cnt_d = lock_cnt;
    tries_inc  = tries + 2'd1;
    case (state)
      IDLE: begin
        if (press) begin
          entry_d  = {entry[5:0], press_digit};
          digits_d = digits + 3'd1;
          if (digits == 3'd3) state_d = CHECK;
        end
      end
      CHECK: begin
        digits_d = 3'd0;
        if (entry == CODE) begin
          pass_d  = 1'b1;
          tries_d = 2'd0;
          state_d = IDLE;
        end else begin
          fail_d  = 1'b1;
          tries_d = tries_inc;
          state_d = (tries_inc == TRY_LIM) ? LOCK : IDLE;
        end
      end
      LOCK: begin
        // locked rises on the first LOCK cycle; counting starts once it is high
        locked_d = 1'b1;
        if (locked) begin
          if (lock_cnt == LOCK_LAST) begin
            locked_d   = 1'b0;
            tries_d    = 2'd0;
            lock_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            lock_cnt_d = lock_cnt + LCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      entry    <= '0;
      digits   <= '0;
      tries    <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      locked   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_d;
      entry    <= entry_d;
      digits   <= digits_d;
      tries    <= tries_d;
      pass     <= pass_d;
      fail     <= fail_d;
      locked   <= locked_d;
      lock_cnt <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: randomized and scenario stimulus for code_lock, checked every
// cycle against a behavioural model plus scenario-level pulse/count checks.
module tb_code_lock;

  localparam int         DEB  = 4;
  localparam int         LOCK = 20;
  localparam int         MAXT = 3;
  localparam logic [7:0] CODE = 8'h1B;
  localparam int         M_IDLE = 0, M_CHECK = 1, M_LOCK = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       pass, fail, locked;
  logic [2:0] digits;
  logic [1:0] tries;

  code_lock #(
    .DEB_CYCLES (DEB),
    .CODE       (CODE),
    .MAX_TRIES  (MAXT),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .pass  (pass),
    .fail  (fail),
    .locked(locked),
    .digits(digits),
    .tries (tries)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int m_s1[4], m_s2[4], m_lvl[4], m_prev[4], m_cnt[4];
  int m_q[$];
  int m_mode, m_left, m_tries;
  bit m_pass, m_fail, m_locked;

  // observation counters
  int         pass_seen, fail_seen, lock_seen;
  int         dtrace[$];
  logic [2:0] last_digits = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference model, evaluated on the pre-edge inputs.
  task automatic model_step();
    int n, d, v;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_prev[i] = 0; m_cnt[i] = 0;
      end
      m_q.delete();
      m_mode = M_IDLE; m_left = 0; m_tries = 0;
      m_pass = 0; m_fail = 0; m_locked = 0;
    end else begin
      n = 0; d = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_lvl[i] == 1 && m_prev[i] == 0) begin n++; d = i; end
      end
      m_pass = 0; m_fail = 0;
      case (m_mode)
        M_IDLE: begin
          if (n == 1) begin
            m_q.push_back(d);
            if (m_q.size() == 4) m_mode = M_CHECK;
          end
        end
        M_CHECK: begin
          v = 0;
          foreach (m_q[k]) v = v * 4 + m_q[k];
          m_q.delete();
          if (v == int'(CODE)) begin
            m_pass = 1; m_tries = 0; m_mode = M_IDLE;
          end else begin
            m_fail = 1; m_tries++;
            if (m_tries == MAXT) begin
              m_mode = M_LOCK; m_left = LOCK + 1;
            end else begin
              m_mode = M_IDLE;
            end
          end
        end
        default: begin
          if (m_left == 1) begin
            m_locked = 0; m_tries = 0; m_mode = M_IDLE;
          end else begin
            m_locked = 1; m_left--;
          end
        end
      endcase
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = m_lvl[i];
        if (m_s2[i] == m_lvl[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == DEB - 1) begin m_lvl[i] = m_s2[i]; m_cnt[i] = 0; end
        else m_cnt[i]++;
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(btn[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pass",   pass,   m_pass);
    chk("fail",   fail,   m_fail);
    chk("locked", locked, m_locked);
    chk("digits", digits, m_q.size());
    chk("tries",  tries,  m_tries);
    if (pass === 1'b1)   pass_seen++;
    if (fail === 1'b1)   fail_seen++;
    if (locked === 1'b1) lock_seen++;
    if (digits !== last_digits) begin
      dtrace.push_back(int'(digits));
      last_digits = digits;
    end
  endtask

  task automatic press(input int d);
    int n;
    btn = 4'(1 << d);
    n = $urandom_range(8, 12);
    repeat (n) tick();
    btn = 4'd0;
    n = $urandom_range(8, 12);
    repeat (n) tick();
  endtask

  task automatic enter(input logic [7:0] v);
    for (int k = 0; k < 4; k++) press(int'(v[7-2*k -: 2]));
  endtask

  task automatic pulse_reset_and_check(input string tag);
    btn   = 4'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk({tag, "_pass"},   pass,   0);
    chk({tag, "_fail"},   fail,   0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_digits"}, digits, 0);
    chk({tag, "_tries"},  tries,  0);
  endtask

  task automatic clear_obs();
    pass_seen = 0; fail_seen = 0; lock_seen = 0;
    dtrace.delete();
  endtask

  int dexp[5] = '{1, 2, 3, 4, 0};

  initial begin
    int v, r, n;
    clear_obs();

    // reset state
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_pass",   pass,   0);
    chk("rst_fail",   fail,   0);
    chk("rst_locked", locked, 0);
    chk("rst_digits", digits, 0);
    chk("rst_tries",  tries,  0);

    // correct entry
    clear_obs();
    enter(CODE);
    chk("ok_pass_cnt", pass_seen, 1);
    chk("ok_fail_cnt", fail_seen, 0);
    chk("ok_tries", tries, 0);
    chk("ok_dseq_len", dtrace.size(), 5);
    for (int k = 0; k < 5; k++) begin
      v = (k < dtrace.size()) ? dtrace[k] : -1;
      chk("ok_dseq", v, dexp[k]);
    end

    // bounce on btn[2], then a held press
    for (int k = 0; k < 10; k++) begin
      btn[2] = ~btn[2];
      repeat (2) tick();
    end
    btn[2] = 1'b1;
    repeat (12) tick();
    btn[2] = 1'b0;
    repeat (12) tick();
    chk("bnc_digits", digits, 1);
    // 3-cycle glitch
    btn[1] = 1'b1;
    repeat (3) tick();
    btn[1] = 1'b0;
    repeat (12) tick();
    chk("glitch_digits", digits, 1);

    // reset after 2 digits, then a full correct entry
    press(0);
    chk("mid_digits", digits, 2);
    pulse_reset_and_check("mid_rst");
    clear_obs();
    enter(CODE);
    chk("mid_after_pass", pass_seen, 1);

    // lockout
    clear_obs();
    for (int t = 1; t <= 3; t++) begin
      enter(8'hFF);
      chk("lk_tries", tries, t);
    end
    chk("lk_locked", locked, 1);
    btn = 4'b0100;
    repeat (8) tick();
    btn = 4'd0;
    chk("lk_digits", digits, 0);
    for (int k = 0; k < 60 && locked === 1'b1; k++) tick();
    chk("lk_release", locked, 0);
    chk("lk_cycles", lock_seen, LOCK);
    chk("lk_fail_cnt", fail_seen, 3);
    chk("lk_tries_after", tries, 0);
    repeat (15) tick();
    chk("lk_digits_after", digits, 0);

    // recovery
    clear_obs();
    enter(8'h00);
    chk("rec_tries1", tries, 1);
    enter(CODE);
    chk("rec_pass_cnt", pass_seen, 1);
    chk("rec_tries0", tries, 0);

    // simultaneous press
    btn = 4'b0011;
    repeat (12) tick();
    btn = 4'd0;
    repeat (12) tick();
    chk("sim_digits", digits, 0);
    press(3);
    chk("sim_single", digits, 1);
    pulse_reset_and_check("sim_rst");

    // reset at lockout cycle 10
    enter(8'hFF);
    enter(8'hFF);
    for (int k = 0; k < 3; k++) press(3);
    btn = 4'b1000;
    for (int k = 0; k < 60 && locked !== 1'b1; k++) tick();
    chk("ml_locked", locked, 1);
    repeat (9) tick();
    pulse_reset_and_check("ml_rst");
    clear_obs();
    enter(CODE);
    chk("ml_pass_cnt", pass_seen, 1);

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if (r < 35) begin
        enter(CODE);
      end else if (r < 60) begin
        enter(8'($urandom_range(0, 255)));
      end else begin
        btn = 4'($urandom_range(0, 15));
        n = $urandom_range(1, 12);
        repeat (n) tick();
        btn = 4'd0;
        n = $urandom_range(1, 12);
        repeat (n) tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
